// File: rtl/iq_pkg.sv
// Shared widths, field offsets and entry layout for the instruction queue.
// The optional IQ_PERF_EN build uses sat_add32 for its counters.
package iq_pkg;

    localparam int PRED_W  = 32;
    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int ENTRY_W = PRED_W + PC_W + INSTR_W;

    localparam int INSTR_LSB = 0;
    localparam int PC_LSB    = INSTR_W;
    localparam int PRED_LSB  = INSTR_W + PC_W;

    typedef struct packed {
        logic [PRED_W-1:0]  pred;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } iq_entry_t;

    function automatic logic [31:0] sat_add32(
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/iq_wrap_add.sv
// Combinational modular add: (ptr + n) mod DEPTH for n <= DEPTH.
// A single compare-subtract suffices, so DEPTH need not be a power of two.
module iq_wrap_add #(
    parameter int  DEPTH = 16,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NW    = $clog2(DEPTH + 1)
) (
    input  logic [PW-1:0] ptr,
    input  logic [NW-1:0] n,
    output logic [PW-1:0] sum
);

    logic [PW:0] s;

    assign s   = {1'b0, ptr} + (PW+1)'(n);
    assign sum = (s >= (PW+1)'(DEPTH)) ? PW'(s - (PW+1)'(DEPTH))
                                       : s[PW-1:0];

endmodule

// File: rtl/iq_multi_buffer.sv
// Multi-entry instruction queue between fetch alignment and decode.
// Define IQ_PERF_EN to add saturating stall/empty/enqueue counters.
module iq_multi_buffer #(
    parameter int  ENTRY_W = iq_pkg::ENTRY_W,
    parameter int  FETCH_W = 8,
    parameter int  ISSUE_W = 4,
    parameter int  DEPTH   = 16,
    localparam int FCW     = $clog2(FETCH_W + 1),
    localparam int ICW     = $clog2(ISSUE_W + 1),
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [FCW-1:0]             in_count,
    input  logic [FETCH_W*ENTRY_W-1:0] in_entries,
    output logic                       in_ready,
    output logic [ISSUE_W-1:0]         out_valid,
    output logic [ISSUE_W*ENTRY_W-1:0] out_entries,
    input  logic [ICW-1:0]             out_take,
    output logic [CW-1:0]              occupancy
`ifdef IQ_PERF_EN
   ,output logic [31:0]                perf_full_stall,
    output logic [31:0]                perf_empty,
    output logic [31:0]                perf_enq_total
`endif
);

    import iq_pkg::*;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [PW-1:0]      head_nx;
    logic [PW-1:0]      tail_nx;
    logic [CW-1:0]      count;
    logic [FCW-1:0]     eff_in;
    logic [FCW-1:0]     enq_n;
    logic [ICW-1:0]     deq_n;
    logic               enq;
    logic [PW-1:0]      waddr [FETCH_W];
    logic [PW-1:0]      raddr [ISSUE_W];

    // Readiness only looks at the registered count, so a full group always fits.
    assign in_ready  = count <= CW'(DEPTH - FETCH_W);
    assign eff_in    = (in_count > FCW'(FETCH_W)) ? FCW'(FETCH_W) : in_count;
    assign enq       = in_valid && in_ready && !flush;
    assign enq_n     = enq ? eff_in : '0;
    assign deq_n     = flush ? '0
                     : (CW'(out_take) > count) ? ICW'(count)
                     : out_take;
    assign occupancy = count;

    iq_wrap_add #(.DEPTH(DEPTH)) u_tail_add (
        .ptr (tail),
        .n   (CW'(enq_n)),
        .sum (tail_nx)
    );

    iq_wrap_add #(.DEPTH(DEPTH)) u_head_add (
        .ptr (head),
        .n   (CW'(deq_n)),
        .sum (head_nx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head_nx;
            tail  <= tail_nx;
            count <= count + CW'(enq_n) - CW'(deq_n);
        end
    end

    for (genvar k = 0; k < FETCH_W; k++) begin : g_wr
        iq_wrap_add #(.DEPTH(DEPTH)) u_waddr (
            .ptr (tail),
            .n   (CW'(k)),
            .sum (waddr[k])
        );
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            for (int k = 0; k < FETCH_W; k++) begin
                if (FCW'(k) < eff_in)
                    mem[waddr[k]] <= in_entries[k*ENTRY_W +: ENTRY_W];
            end
        end
    end

    for (genvar k = 0; k < ISSUE_W; k++) begin : g_rd
        iq_wrap_add #(.DEPTH(DEPTH)) u_raddr (
            .ptr (head),
            .n   (CW'(k)),
            .sum (raddr[k])
        );
        assign out_valid[k] = CW'(k) < count;
        assign out_entries[k*ENTRY_W +: ENTRY_W] = mem[raddr[k]];
    end

`ifdef IQ_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_full_stall <= '0;
            perf_empty      <= '0;
            perf_enq_total  <= '0;
        end else begin
            perf_full_stall <= sat_add32(perf_full_stall,
                                         {31'b0, in_valid && !in_ready});
            perf_empty      <= sat_add32(perf_empty,
                                         {31'b0, count == '0});
            perf_enq_total  <= sat_add32(perf_enq_total, 32'(enq_n));
        end
    end
`endif

endmodule

// File: tb/tb_iq_multi_buffer.sv
// Scoreboard bench for iq_multi_buffer (DEPTH=16, FETCH_W=8, ISSUE_W=4).
// Build with +define+IQ_PERF_EN to also exercise the perf counters.
module tb_iq_multi_buffer;

    import iq_pkg::*;

    localparam int EW = 96;
    localparam int FW = 8;
    localparam int IW = 4;
    localparam int DP = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic [3:0]      in_count;
    logic [FW*EW-1:0] in_entries;
    logic            in_ready;
    logic [IW-1:0]   out_valid;
    logic [IW*EW-1:0] out_entries;
    logic [2:0]      out_take;
    logic [4:0]      occupancy;
`ifdef IQ_PERF_EN
    logic [31:0]     perf_full_stall;
    logic [31:0]     perf_empty;
    logic [31:0]     perf_enq_total;
`endif

    iq_multi_buffer #(
        .ENTRY_W (EW),
        .FETCH_W (FW),
        .ISSUE_W (IW),
        .DEPTH   (DP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_count    (in_count),
        .in_entries  (in_entries),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_entries (out_entries),
        .out_take    (out_take),
        .occupancy   (occupancy)
`ifdef IQ_PERF_EN
       ,.perf_full_stall (perf_full_stall),
        .perf_empty      (perf_empty),
        .perf_enq_total  (perf_enq_total)
`endif
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [EW-1:0] q[$];
    logic [31:0] next_pc = 32'h100;

    task automatic chk(input string tag, input logic [95:0] got,
                       input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk(input logic [31:0] pc);
        iq_entry_t e;
        e.pred  = ~pc;
        e.pc    = pc;
        e.instr = pc ^ 32'h1357_9BDF;
        return e;
    endfunction

    task automatic check_outputs();
        int n;
        logic [IW-1:0] m;
        n = q.size();
        m = (n >= IW) ? 4'hF : 4'((1 << n) - 1);
        chk("occupancy", 96'(occupancy), 96'(n));
        chk("in_ready", 96'(in_ready), 96'((DP - n) >= FW));
        chk("out_valid", 96'(out_valid), 96'(m));
        for (int k = 0; k < IW; k++)
            if (k < n)
                chk($sformatf("slot%0d", k), out_entries[k*EW +: EW], q[k]);
    endtask

    task automatic step(input bit v, input int cnt, input int take,
                        input bit fl);
        int eff;
        int dq;
        bit rdy;
        check_outputs();
        in_valid = v;
        in_count = 4'(cnt);
        out_take = 3'(take);
        flush    = fl;
        for (int k = 0; k < FW; k++)
            in_entries[k*EW +: EW] = mk(next_pc + 32'(4 * k));
        eff = (cnt > FW) ? FW : cnt;
        rdy = (DP - q.size()) >= FW;
        if (fl) begin
            q.delete();
        end else begin
            dq = (take < q.size()) ? take : q.size();
            repeat (dq) void'(q.pop_front());
            if (v && rdy) begin
                for (int k = 0; k < eff; k++)
                    q.push_back(mk(next_pc + 32'(4 * k)));
                next_pc = next_pc + 32'(4 * eff);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_count   = '0;
        out_take   = '0;
        in_entries = '0;
        #12;
        check_outputs();
        rst = 1'b1;
        @(posedge clk);
        #1;

        // basic enqueue, oldest first
        step(1, 5, 0, 0);
        chk("pc0", 96'(out_entries[PC_LSB +: 32]), 96'(32'h100));
        // back-pressure at count 9, then dequeue 4
        step(1, 4, 0, 0);
        step(1, 8, 0, 0);
        step(0, 0, 4, 0);
        step(0, 0, 0, 0);

        // move head to 14 with an empty queue, then wrap
        step(0, 0, 0, 1);
        step(1, 7, 0, 0);
        step(1, 7, 0, 0);
        step(0, 0, 4, 0);
        step(0, 0, 4, 0);
        step(0, 0, 4, 0);
        step(0, 0, 2, 0);
        step(1, 6, 0, 0);
        step(0, 0, 0, 0);

        // take exceeds count with simultaneous enqueue
        step(0, 0, 4, 0);
        step(1, 3, 4, 0);
        step(0, 0, 0, 0);

        // flush beats enqueue and dequeue
        step(1, 8, 4, 1);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);

        // in_count above FETCH_W clamps; in_count 0 writes nothing
        step(0, 0, 0, 1);
        step(1, 10, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 4, 0);

        // asynchronous reset mid-stream with 7 entries stored
        step(0, 0, 0, 1);
        step(1, 7, 0, 0);
        check_outputs();
        in_valid = 1'b0;
        #3;
        rst = 1'b0;
        q.delete();
        #1;
        check_outputs();
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
`ifdef IQ_PERF_EN
        chk("perf_empty", 96'(perf_empty), 96'(4));
        chk("perf_enq", 96'(perf_enq_total), 96'(0));
`endif
        step(1, 2, 0, 0);
        chk("pc_after_rst", 96'(out_entries[PC_LSB +: 32]),
            96'(next_pc - 32'd8));

        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), $urandom_range(0, 10),
                 $urandom_range(0, 4), ($urandom_range(0, 19) == 0));
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
